// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and
// holds the returned word in a single-entry IR handed to the decoder.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic [4:0]  opcode,
   output logic        ir_len_err
);

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] ir_pc_q;
   logic        ir_valid_q;
   logic        req_fire_c;
   logic [31:0] redirect_tgt_c;
   logic        unused_redirect_lsb_c;

   // A request may go out only when the IR is empty or drains this cycle.
   assign imem_req_valid = !rst && (state_q == S_REQ) && (!ir_valid_q || ir_ready);
   assign req_fire_c     = imem_req_valid && imem_req_ready;
   assign imem_addr      = pc_q;

   // Redirect targets are word aligned; the low two bits are ignored.
   assign redirect_tgt_c        = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb_c = ^redirect_pc[1:0];

   assign ir_valid   = ir_valid_q;
   assign ir         = ir_q;
   assign ir_pc      = ir_pc_q;
   assign opcode     = ir_q[6:2];
   assign ir_len_err = ir_valid_q && (ir_q[1:0] != 2'b11);

   // Fetch FSM, PC and instruction register; redirect overrides all other events.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= {RESET_PC[31:2], 2'b00};
         ir_q       <= NOP_INSN;
         ir_pc_q    <= 32'h0000_0000;
         ir_valid_q <= 1'b0;
      end else begin
         if (ir_valid_q && ir_ready) begin
            ir_valid_q <= 1'b0;
         end
         if (redirect_valid) begin
            pc_q       <= redirect_tgt_c;
            ir_valid_q <= 1'b0;
            case (state_q)
               S_REQ:   if (req_fire_c) state_q <= S_DRAIN;
               S_WAIT:  state_q <= imem_resp_valid ? S_REQ : S_DRAIN;
               S_DRAIN: if (imem_resp_valid) state_q <= S_REQ;
               default: state_q <= S_REQ;
            endcase
         end else begin
            case (state_q)
               S_REQ: begin
                  if (req_fire_c) state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (imem_resp_valid) begin
                     ir_q       <= imem_resp_data;
                     ir_pc_q    <= pc_q;
                     ir_valid_q <= 1'b1;
                     pc_q       <= pc_q + PC_STEP;
                     state_q    <= S_REQ;
                  end
               end
               S_DRAIN: begin
                  // Response to a cancelled request: data is dropped, PC kept.
                  if (imem_resp_valid) state_q <= S_REQ;
               end
               default: state_q <= S_REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a throughput sequence and a
// randomized run scored against a transaction-level model of the stage.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic [4:0]  opcode;
   logic        ir_len_err;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .ir_valid        (ir_valid),
      .ir_ready        (ir_ready),
      .ir              (ir),
      .ir_pc           (ir_pc),
      .opcode          (opcode),
      .ir_len_err      (ir_len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
   endtask

   // One cycle of stimulus with the outputs expected just before the edge.
   typedef struct {
      logic        rst;
      logic        rr;
      logic        rv;
      logic [31:0] rd;
      logic        rdv;
      logic [31:0] rpc;
      logic        ird;
      logic        erqv;
      logic [31:0] eaddr;
      logic        eirv;
      logic [31:0] eir;
      logic [31:0] eirpc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                      input logic rdv, input logic [31:0] rpc, input logic ird,
                      input logic erqv, input logic [31:0] eaddr, input logic eirv,
                      input logic [31:0] eir, input logic [31:0] eirpc);
      vec_t v;
      v.rst = r; v.rr = rr; v.rv = rv; v.rd = rd; v.rdv = rdv; v.rpc = rpc; v.ird = ird;
      v.erqv = erqv; v.eaddr = eaddr; v.eirv = eirv; v.eir = eir; v.eirpc = eirpc;
      tbl.push_back(v);
   endtask

   // Memory image used by the random phase; a few words carry a bad length field.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      h = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      if (h[7:5] == 3'd0) return h;
      return {h[31:2], 2'b11};
   endfunction

   // Random-phase model state
   logic        m_irv;
   logic [31:0] m_irpc;
   logic [31:0] m_fetch;
   logic        m_out;
   logic        m_cancel;
   int          m_cnt;
   logic [31:0] m_addr;
   int          delivered;

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; ir_ready = 1'b0;

      // Straight-line fetch, back-pressure, redirects, wrap, reset mid-WAIT
      add(1,1,0,32'h0,0,32'h0,1,         0,32'h0,0,32'h13,32'h0);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h0,0,32'h13,32'h0);
      add(0,1,1,32'h33,0,32'h0,1,        0,32'h0,0,32'h13,32'h0);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h4,1,32'h33,32'h0);
      add(0,1,1,32'h0040_0093,0,32'h0,1, 0,32'h4,0,32'h33,32'h0);
      for (int i = 0; i < 5; i++)
         add(0,1,0,32'h0,0,32'h0,0,      0,32'h8,1,32'h0040_0093,32'h4);
      add(0,0,0,32'h0,0,32'h0,1,         1,32'h8,1,32'h0040_0093,32'h4);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h8,0,32'h0040_0093,32'h4);
      add(0,0,0,32'h0,1,32'h100,1,       0,32'h8,0,32'h0040_0093,32'h4);
      add(0,0,1,32'hDEAD_BEEF,0,32'h0,1, 0,32'h100,0,32'h0040_0093,32'h4);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h100,0,32'h0040_0093,32'h4);
      add(0,0,1,32'h6F,0,32'h0,1,        0,32'h100,0,32'h0040_0093,32'h4);
      add(0,1,0,32'h0,0,32'h0,0,         0,32'h104,1,32'h6F,32'h100);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h104,1,32'h6F,32'h100);
      add(0,0,1,32'h1111_1111,1,32'h200,1, 0,32'h104,0,32'h6F,32'h100);
      add(0,0,0,32'h0,0,32'h0,1,         1,32'h200,0,32'h6F,32'h100);
      add(0,0,0,32'h0,1,32'hFFFF_FFFE,1, 1,32'h200,0,32'h6F,32'h100);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'hFFFF_FFFC,0,32'h6F,32'h100);
      add(0,0,1,32'h1,0,32'h0,1,         0,32'hFFFF_FFFC,0,32'h6F,32'h100);
      add(0,1,0,32'h0,0,32'h0,0,         0,32'h0,1,32'h1,32'hFFFF_FFFC);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h0,1,32'h1,32'hFFFF_FFFC);
      add(0,0,1,32'h33,0,32'h0,1,        0,32'h0,0,32'h1,32'hFFFF_FFFC);
      add(0,1,0,32'h0,0,32'h0,1,         1,32'h4,1,32'h33,32'h0);
      add(1,0,0,32'h0,0,32'h0,1,         0,32'h4,0,32'h33,32'h0);
      add(0,0,0,32'h0,0,32'h0,1,         1,32'h0,0,32'h13,32'h0);

      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         vec_t v;
         logic [31:0] e;
         v = tbl[i];
         e = v.eir;
         @(negedge clk);
         rst = v.rst; imem_req_ready = v.rr; imem_resp_valid = v.rv; imem_resp_data = v.rd;
         redirect_valid = v.rdv; redirect_pc = v.rpc; ir_ready = v.ird;
         #1;
         chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(v.erqv));
         chk($sformatf("v%0d imem_addr", i), imem_addr, v.eaddr);
         chk($sformatf("v%0d ir_valid", i), 32'(ir_valid), 32'(v.eirv));
         chk($sformatf("v%0d ir", i), ir, v.eir);
         chk($sformatf("v%0d ir_pc", i), ir_pc, v.eirpc);
         chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(e[6:2]));
         chk($sformatf("v%0d len_err", i), 32'(ir_len_err), 32'(v.eirv && (e[1:0] != 2'b11)));
      end

      // Peak throughput: zero-wait memory, decoder always ready
      begin
         logic pend;
         int   nvalid;
         int   nacc;
         pend = 1'b0; nvalid = 0; nacc = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = pend;
            imem_resp_data = 32'h0000_0033; redirect_valid = 1'b0; ir_ready = 1'b1;
            #1;
            if (ir_valid) nvalid++;
            pend = imem_req_valid && imem_req_ready;
            if (pend) begin
               chk("tp_addr", imem_addr, 32'(nacc * 4));
               nacc++;
            end
         end
         chk("tp_ir_count", 32'(nvalid), 32'd9);
         chk("tp_req_count", 32'(nacc), 32'd10);
      end

      // Randomized run against the transaction-level model
      @(negedge clk);
      rst = 1'b1; imem_resp_valid = 1'b0; redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      m_irv = 1'b0; m_irpc = 32'h0; m_fetch = 32'h0; m_out = 1'b0; m_cancel = 1'b0;
      m_cnt = 0; m_addr = 32'h0; delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        acc;
         logic        kept;
         logic        nirv;
         logic [31:0] r;
         logic [31:0] w;
         if (cyc != 0) @(negedge clk);
         rst = 1'b0;
         imem_resp_valid = m_out && (m_cnt == 1);
         imem_resp_data  = imem_resp_valid ? mem_word(m_addr) : $urandom;
         imem_req_ready  = ($urandom_range(0, 9) < 6);
         ir_ready        = ($urandom_range(0, 9) < 7);
         redirect_valid  = ($urandom_range(0, 19) == 0);
         r = $urandom;
         if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
         redirect_pc = r;
         #1;
         chk("rnd ir_valid", 32'(ir_valid), 32'(m_irv));
         chk("rnd req_valid", 32'(imem_req_valid), 32'(!m_out && (!m_irv || ir_ready)));
         if (imem_req_valid) chk("rnd imem_addr", imem_addr, m_fetch);
         if (m_irv) begin
            w = mem_word(m_irpc);
            chk("rnd ir_pc", ir_pc, m_irpc);
            chk("rnd ir", ir, w);
            chk("rnd opcode", 32'(opcode), 32'(w[6:2]));
            chk("rnd len_err", 32'(ir_len_err), 32'(w[1:0] != 2'b11));
            if (ir_ready) delivered++;
         end else begin
            chk("rnd len_err_idle", 32'(ir_len_err), 32'd0);
         end

         acc  = imem_req_valid && imem_req_ready;
         kept = imem_resp_valid && !m_cancel && !redirect_valid;
         nirv = kept || (m_irv && !ir_ready && !redirect_valid);
         if (kept) begin
            m_irpc  = m_addr;
            m_fetch = m_addr + 32'd4;
         end
         if (redirect_valid) m_fetch = {redirect_pc[31:2], 2'b00};
         if (imem_resp_valid) m_out = 1'b0;
         else if (m_out) begin
            m_cnt--;
            if (redirect_valid) m_cancel = 1'b1;
         end
         if (acc) begin
            if (m_out) chk("rnd single_outstanding", 32'(m_out), 32'd0);
            m_out    = 1'b1;
            m_addr   = imem_addr;
            m_cnt    = $urandom_range(1, 3);
            m_cancel = redirect_valid;
         end
         m_irv = nirv;
      end
      chk("rnd progress", 32'(delivered >= 100), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the main decoder. It owns the program counter and issues one instruction-memory read at a time. It holds the returned word in a single-entry instruction register (IR) and presents it with a valid/ready handshake, driving `opcode` = IR[6:2] straight into the decoder. Redirects from branch and jump resolution (JAL/JALR/B) flush the stage and restart fetch at the new address.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  request address; equals PC.
- `imem_resp_valid`  in  1  read data valid. Never asserted in the same cycle the request is accepted.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle redirect strobe.
- `redirect_pc`  in  32  redirect target.
- `ir_valid`  out  1  IR holds an instruction for the decoder.
- `ir_ready`  in  1  decoder consumes IR this cycle.
- `ir`  out  32  instruction word.
- `ir_pc`  out  32  address of `ir`.
- `opcode`  out  5  IR[6:2], feeds the decoder's opcode input.
- `ir_len_err`  out  1  IR[1:0] != 2'b11 while `ir_valid`; 0 otherwise.

## Operation
- **State machine:** three states, REQ, WAIT, DRAIN. At most one request is outstanding at any time.
- **REQ**
  - Drives `imem_req_valid` = !rst && (!ir_valid || ir_ready), with `imem_addr` = PC.
  - On acceptance (req_valid && req_ready), go to WAIT.
- **WAIT**
  - `imem_req_valid` = 0.
  - On `imem_resp_valid`: IR <= resp_data, `ir_pc` <= PC, `ir_valid` <= 1, PC <= PC + 4 (mod 2^32), go to REQ.
  - IR is always empty when a response arrives. This holds because a request is only issued when IR is empty or being consumed.
- **DRAIN**
  - Waits for the response to a cancelled request.
  - On `imem_resp_valid`: discard the data, leave PC unchanged, go to REQ.
- **IR consumption:** `ir_valid && ir_ready` clears `ir_valid` next cycle unless a new response loads IR in the same cycle.
- **IR stability:** IR, `ir_pc` and `ir_valid` hold stable while `ir_valid && !ir_ready`.
- **Redirect:** `redirect_valid` has priority over every other event. Effects:
  - PC <= {redirect_pc[31:2], 2'b00}; bits [1:0] are dropped.
  - `ir_valid` <= 0, even if IR is being consumed the same cycle.
  - Next state depends on the current state:
    - REQ with no acceptance this cycle: stays REQ. `imem_addr` changes to the new PC next cycle; this is the only case where an unaccepted address may change.
    - REQ with acceptance this cycle: go to DRAIN.
    - WAIT without a response: go to DRAIN.
    - WAIT with a response the same cycle: drop the response, go to REQ.
    - DRAIN: stay in DRAIN; if a response arrives the same cycle, go to REQ.
- **Reset:** effects while `rst` is high:
  - State <= REQ, PC <= RESET_PC.
  - `ir_valid` <= 0, IR <= 32'h0000_0013 (NOP), `ir_pc` <= 0.
  - `imem_req_valid` = 0 combinationally.
  - A reset mid-request abandons the transaction. The memory is reset by the same `rst`.

## Timing
- **Reset values of outputs:** `imem_req_valid`=0, `imem_addr`=RESET_PC, `ir_valid`=0, `ir`=32'h13, `ir_pc`=0, `opcode`=5'b00100, `ir_len_err`=0.
- **First request:** `imem_req_valid`=1 in the first cycle after `rst` falls.
- **Latency:** request accepted at cycle t, response at t+k (k≥1), then `ir_valid` high at t+k+1.
- **Peak throughput:** one instruction per 2 cycles, with a zero-wait memory and `ir_ready` held at 1.
- **Redirect timing:**
  - Redirect at cycle t: `ir_valid`=0 at t+1.
  - With no request in flight, the new address is presented at t+1.
  - With a request in flight, the new address is presented in the cycle after the drained response.
- **Combinational paths:** `opcode` and `ir_len_err` are combinational from IR.

## Test plan
- **Reset then straight-line fetch:** RESET_PC=0, memory ready with 1-cycle response, `ir_ready`=1. Expected: addresses 0, 4, 8 issued on alternating cycles; `ir_pc` follows 0, 4, 8; `opcode` matches IR[6:2] (e.g. 0x00000033 gives 5'b01100).
- **Back-pressure:** hold `ir_ready`=0 for 5 cycles with IR full. Expected: `imem_req_valid`=0 and IR/`ir_pc` stable. Releasing `ir_ready` issues the request in that same cycle.
- **Redirect in WAIT:** redirect_pc=0x100 with response pending. Expected: stale response discarded, `ir_valid` stays 0, next request address 0x100, next `ir_pc`=0x100.
- **Redirect coincident with response and consume:** in a single cycle assert redirect, response and `ir_ready`. Expected: `ir_valid`=0 next cycle, PC=redirect target, state REQ.
- **Misaligned redirect and wrap:** redirect_pc=0xFFFF_FFFE. Expected: fetch 0xFFFF_FFFC, then 0x0000_0000. Response 0x0000_0001 raises `ir_len_err`=1.
- **Reset mid-WAIT:** assert `rst` one cycle while a request is outstanding. Expected: all outputs at reset values, first request at RESET_PC.
